bit_window3: RTL and testbench
==============================

BIT_WINDOW3 -- requirements
Module: bit_window3

Interface
REQ-001 SHALL have parameter IDX_W, default 8, giving the width of the window-index counter in bits.
REQ-002 SHALL have clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have in_bit  input  1  serial data bit x[n].
REQ-005 SHALL have in_valid  input  1  in_bit is valid.
REQ-006 SHALL have in_last  input  1  in_bit is the final bit of the current frame; qualified by in_valid.
REQ-007 SHALL have in_ready  output  1  block accepts in_bit this cycle.
REQ-008 SHALL have win_a  output  1  window tap x[n-1], the oldest bit; drives the 3-input truth-table/median stage select MSB.
REQ-009 SHALL have win_b  output  1  window tap x[n], the centre bit.
REQ-010 SHALL have win_c  output  1  window tap x[n+1], the newest bit; select LSB.
REQ-011 SHALL have out_valid  output  1  window taps are valid.
REQ-012 SHALL have out_last  output  1  window is the final one of its frame.
REQ-013 SHALL have out_ready  input  1  downstream accepts the window.
REQ-014 SHALL have win_idx  output  IDX_W  index of the presented window within its frame, starting at 0.

Function
REQ-015 SHALL implement an input transfer when in_valid and in_ready are both 1, and an output transfer when out_valid and out_ready are both 1.
REQ-016 SHALL hold two bit registers: prev (x[n-1]) and cur (x[n]).
REQ-017 SHALL implement a state machine with three states.
- EMPTY: no bits held.
- HOLD: prev and cur are valid.
- FLUSH: the last bit of the frame has been accepted and the final window is pending.
REQ-018 SHALL define slot_free = !out_valid || out_ready.
REQ-019 SHALL drive in_ready = 1 in EMPTY, slot_free in HOLD, and 0 in FLUSH.
REQ-020 SHALL, on an input transfer in EMPTY:
- load prev and cur with in_bit (left-edge replication);
- go to FLUSH if in_last, else go to HOLD;
- emit no window.
REQ-021 SHALL, on an input transfer in HOLD:
- load the output register with (win_a, win_b, win_c) = (prev, cur, in_bit) and out_last = 0;
- then set prev <= cur and cur <= in_bit;
- go to FLUSH if in_last, else stay in HOLD.
REQ-022 SHALL, in FLUSH when slot_free:
- load the output register with (prev, cur, cur) (right-edge replication) and out_last = 1;
- go to EMPTY.
REQ-023 SHALL set out_valid on any output-register load, clear it on an output transfer with no concurrent load, and keep it 1 when a load and an output transfer coincide.
REQ-024 SHALL hold all outputs stable while out_valid = 1 and out_ready = 0.
REQ-025 SHALL produce exactly N windows for an N-bit frame, including N = 1, which produces the single window (x0, x0, x0) with out_last = 1.
REQ-026 SHALL have a latency of one cycle from the input transfer that completes a window to out_valid = 1.
REQ-027 SHALL sustain one window per cycle in HOLD when out_ready = 1 continuously.
REQ-028 SHALL support back-to-back frames: the first bit of the next frame SHALL be accepted in the cycle after the FLUSH window is loaded.
REQ-029 SHALL increment an internal window counter on each window load and load win_idx from it together with the window, so the first window of a frame carries win_idx = 0.
REQ-030 SHALL wrap the window counter modulo 2^IDX_W and reset it to 0 after the out_last window load.
REQ-031 SHALL ignore in_bit and in_last when in_valid = 0.

Reset
REQ-032 SHALL, while rst_n = 0 and independent of clk, force:
- state = EMPTY;
- prev = cur = 0;
- out_valid = out_last = 0;
- win_a = win_b = win_c = 0;
- win_idx = 0 and window counter = 0.
REQ-033 SHALL discard a partially received frame when reset is asserted mid-frame; after release the next accepted bit SHALL be treated as the first bit of a new frame.
REQ-034 SHALL drive in_ready = 1 in the first cycle after reset release.

Verification
REQ-035 Frame 1,0,1,1 (last on 4th bit) with out_ready = 1 -> windows (1,1,0) idx0, (1,0,1) idx1, (0,1,1) idx2, then (1,1,1) idx3 with out_last = 1.
REQ-036 Single-bit frame 0 with in_last -> one window (0,0,0), out_last = 1, win_idx = 0; then in_ready = 1 and state EMPTY.
REQ-037 Frame 1,1,0 with out_ready held 0 for 3 cycles after the first window -> window (1,1,1) holds stable, in_ready = 0 while held, and no window is lost or duplicated after out_ready returns to 1.
REQ-038 Back-to-back frames 0,1(last) then 1,0(last) with continuous valid/ready -> windows (0,0,1), (0,1,1) last, (1,1,0), (1,0,0) last, with win_idx 0,1,0,1.
REQ-039 rst_n pulsed low after 2 bits of a 5-bit frame -> all outputs 0 immediately; the next bit 1 followed by bit 0 (last) yields (1,1,0) then (1,0,0) last.
REQ-040 With IDX_W = 2, a 6-bit frame -> win_idx sequence 0,1,2,3,0,1 and out_last only on the 6th window.

Source files
------------

// File: rtl/bit_window3.sv
// bit_window3 -- slides a 3-bit window over a framed serial bit stream.
//
// Every accepted bit x[n] produces the window (x[n-1], x[n], x[n+1]); the
// frame edges are handled by replicating the first and the last bit, so an
// N-bit frame yields exactly N windows. The windows feed a 3-input
// truth-table/median stage with win_a as the select MSB and win_c as the
// select LSB.
//
// Ports
//   clk        in   single clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   in_bit     in   serial data bit
//   in_valid   in   in_bit is valid
//   in_last    in   in_bit is the final bit of its frame (qualified by in_valid)
//   in_ready   out  block accepts in_bit this cycle
//   win_a      out  tap x[n-1] (oldest)
//   win_b      out  tap x[n]   (centre)
//   win_c      out  tap x[n+1] (newest)
//   out_valid  out  window taps are valid
//   out_last   out  window is the final one of its frame
//   out_ready  in   downstream accepts the window
//   win_idx    out  index of the presented window within its frame
module bit_window3 #(
    parameter int IDX_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_bit,
    input  logic             in_valid,
    input  logic             in_last,
    output logic             in_ready,
    output logic             win_a,
    output logic             win_b,
    output logic             win_c,
    output logic             out_valid,
    output logic             out_last,
    input  logic             out_ready,
    output logic [IDX_W-1:0] win_idx
);

    typedef enum logic [1:0] {
        EMPTY,
        HOLD,
        FLUSH
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             prev;
    logic             cur;
    logic [IDX_W-1:0] cnt;

    logic slot_free;
    logic in_xfer;
    logic out_xfer;
    logic load_hold;
    logic load_flush;
    logic load;

    // The output register may be refilled whenever it is empty or being
    // drained in this same cycle.
    assign slot_free  = !out_valid || out_ready;
    assign in_ready   = (state == EMPTY) || ((state == HOLD) && slot_free);
    assign in_xfer    = in_valid && in_ready;
    assign out_xfer   = out_valid && out_ready;
    assign load_hold  = (state == HOLD) && in_xfer;
    assign load_flush = (state == FLUSH) && slot_free;
    assign load       = load_hold || load_flush;

    always_comb begin
        state_nxt = state;
        case (state)
            EMPTY: begin
                if (in_xfer) begin
                    state_nxt = in_last ? FLUSH : HOLD;
                end
            end
            HOLD: begin
                if (in_xfer && in_last) begin
                    state_nxt = FLUSH;
                end
            end
            FLUSH: begin
                if (slot_free) begin
                    state_nxt = EMPTY;
                end
            end
            default: state_nxt = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // Bit history. The first bit of a frame fills both registers so the
    // first window sees x[-1] = x[0].
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev <= 1'b0;
            cur  <= 1'b0;
        end else if (in_xfer) begin
            if (state == EMPTY) begin
                prev <= in_bit;
                cur  <= in_bit;
            end else begin
                prev <= cur;
                cur  <= in_bit;
            end
        end
    end

    // Output register. The flush window repeats cur as x[n+1], and the
    // counter restarts after it so the next frame begins at index 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_a     <= 1'b0;
            win_b     <= 1'b0;
            win_c     <= 1'b0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            win_idx   <= '0;
            cnt       <= '0;
        end else begin
            if (load) begin
                win_a     <= prev;
                win_b     <= cur;
                win_c     <= load_flush ? cur : in_bit;
                out_last  <= load_flush;
                out_valid <= 1'b1;
                win_idx   <= cnt;
                cnt       <= load_flush ? '0 : cnt + IDX_W'(1);
            end else if (out_xfer) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_bit_window3.sv
module tb_bit_window3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       in_bit = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_last = 1'b0;
    logic       out_ready = 1'b1;

    logic       in_ready, win_a, win_b, win_c, out_valid, out_last;
    logic [7:0] win_idx;
    logic       in_ready2, win_a2, win_b2, win_c2, out_valid2, out_last2;
    logic [1:0] win_idx2;

    int errors = 0;
    int checks = 0;

    logic [3:0] q_win[$];
    logic [7:0] q_idx[$];
    logic [1:0] q_idx2[$];

    bit_window3 #(.IDX_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_bit(in_bit), .in_valid(in_valid),
        .in_last(in_last), .in_ready(in_ready), .win_a(win_a), .win_b(win_b),
        .win_c(win_c), .out_valid(out_valid), .out_last(out_last),
        .out_ready(out_ready), .win_idx(win_idx)
    );

    bit_window3 #(.IDX_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_bit(in_bit), .in_valid(in_valid),
        .in_last(in_last), .in_ready(in_ready2), .win_a(win_a2), .win_b(win_b2),
        .win_c(win_c2), .out_valid(out_valid2), .out_last(out_last2),
        .out_ready(out_ready), .win_idx(win_idx2)
    );

    always #5 clk = ~clk;

    // Record every window that will be transferred at the next rising edge.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            q_win.push_back({win_a, win_b, win_c, out_last});
            q_idx.push_back(win_idx);
            q_idx2.push_back(win_idx2);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_q();
        q_win.delete();
        q_idx.delete();
        q_idx2.delete();
    endtask

    // Present a bit and hold it until accepted; returns 1 time unit after
    // the accepting edge with in_valid still asserted.
    task automatic send_bit(input logic b, input logic last);
        bit ok;
        in_valid = 1'b1;
        in_bit   = b;
        in_last  = last;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("send_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        in_bit   = 1'b0;
        in_last  = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_win(input string tag, input int k, input logic [3:0] w, input logic [7:0] idx);
        if (k < q_win.size()) begin
            check({tag, "_win"}, 32'(q_win[k]), 32'(w));
            check({tag, "_idx"}, 32'(q_idx[k]), 32'(idx));
        end else begin
            check({tag, "_missing"}, 32'(q_win.size()), 32'(k + 1));
        end
    endtask

    initial begin
        // Reset state
        #1 rst_n = 1'b0;
        #2;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_taps", 32'({win_a, win_b, win_c, out_last}), 32'd0);
        check("rst_idx", 32'(win_idx), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;

        // Frame 1,0,1,1 with out_ready = 1
        clear_q();
        out_ready = 1'b1;
        send_bit(1'b1, 1'b0);
        check("t1_no_early_win", 32'(out_valid), 32'd0);
        send_bit(1'b0, 1'b0);
        check("t1_latency", 32'(out_valid), 32'd1);
        check("t1_first_taps", 32'({win_a, win_b, win_c}), 32'b110);
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b1);
        idle(4);
        check("t1_count", 32'(q_win.size()), 32'd4);
        expect_win("t1_w0", 0, 4'b1100, 8'd0);
        expect_win("t1_w1", 1, 4'b1010, 8'd1);
        expect_win("t1_w2", 2, 4'b0110, 8'd2);
        expect_win("t1_w3", 3, 4'b1111, 8'd3);

        // Single-bit frame 0
        clear_q();
        send_bit(1'b0, 1'b1);
        idle(3);
        check("t2_count", 32'(q_win.size()), 32'd1);
        expect_win("t2_w0", 0, 4'b0001, 8'd0);
        check("t2_in_ready", 32'(in_ready), 32'd1);

        // Frame 1,1,0 with downstream stalled after the first window
        clear_q();
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        out_ready = 1'b0;
        in_bit    = 1'b0;
        in_last   = 1'b1;
        in_valid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t3_hold_valid", 32'(out_valid), 32'd1);
            check("t3_hold_taps", 32'({win_a, win_b, win_c, out_last}), 32'b1110);
            check("t3_hold_in_ready", 32'(in_ready), 32'd0);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        send_bit(1'b0, 1'b1);
        idle(4);
        check("t3_count", 32'(q_win.size()), 32'd3);
        expect_win("t3_w0", 0, 4'b1110, 8'd0);
        expect_win("t3_w1", 1, 4'b1100, 8'd1);
        expect_win("t3_w2", 2, 4'b1001, 8'd2);

        // Back-to-back frames 0,1(last) then 1,0(last)
        clear_q();
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b1);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b1);
        idle(4);
        check("t4_count", 32'(q_win.size()), 32'd4);
        expect_win("t4_w0", 0, 4'b0010, 8'd0);
        expect_win("t4_w1", 1, 4'b0111, 8'd1);
        expect_win("t4_w2", 2, 4'b1100, 8'd0);
        expect_win("t4_w3", 3, 4'b1001, 8'd1);

        // Reset mid-frame after 2 bits of a 5-bit frame
        clear_q();
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        in_valid = 1'b0;
        in_last  = 1'b0;
        rst_n    = 1'b0;
        #2;
        check("t5_rst_valid", 32'(out_valid), 32'd0);
        check("t5_rst_taps", 32'({win_a, win_b, win_c, out_last}), 32'd0);
        check("t5_rst_idx", 32'(win_idx), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("t5_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        clear_q();
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b1);
        idle(4);
        check("t5_count", 32'(q_win.size()), 32'd2);
        expect_win("t5_w0", 0, 4'b1100, 8'd0);
        expect_win("t5_w1", 1, 4'b1001, 8'd1);

        // 6-bit frame: narrow counter on dut2 wraps
        clear_q();
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        send_bit(1'b0, 1'b1);
        idle(4);
        check("t6_count", 32'(q_win.size()), 32'd6);
        expect_win("t6_w0", 0, 4'b1100, 8'd0);
        expect_win("t6_w1", 1, 4'b1010, 8'd1);
        expect_win("t6_w2", 2, 4'b0110, 8'd2);
        expect_win("t6_w3", 3, 4'b1100, 8'd3);
        expect_win("t6_w4", 4, 4'b1000, 8'd4);
        expect_win("t6_w5", 5, 4'b0001, 8'd5);
        if (q_idx2.size() == 6) begin
            check("t6_idx2_0", 32'(q_idx2[0]), 32'd0);
            check("t6_idx2_1", 32'(q_idx2[1]), 32'd1);
            check("t6_idx2_2", 32'(q_idx2[2]), 32'd2);
            check("t6_idx2_3", 32'(q_idx2[3]), 32'd3);
            check("t6_idx2_4", 32'(q_idx2[4]), 32'd0);
            check("t6_idx2_5", 32'(q_idx2[5]), 32'd1);
        end else begin
            check("t6_idx2_count", 32'(q_idx2.size()), 32'd6);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
